// File: rtl/lif_spike_monitor.sv
// Spike-rate monitor for the LIF neuron output.
// Counts rising edges of spike_in over a programmable window of window_len+1 cycles and
// publishes the count once per window with a one-cycle rate_valid strobe.
// Optional feature macro: LIF_MON_ISI_EN adds inter-spike-interval measurement
// (isi_out / isi_valid ports and the ISI_W parameter).
module lif_spike_monitor #(
    parameter int unsigned CNT_W = 8,
    parameter int unsigned WIN_W = 8
`ifdef LIF_MON_ISI_EN
    ,
    parameter int unsigned ISI_W = 8
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             spike_in,
    input  logic             enable,
    input  logic [WIN_W-1:0] window_len,
    output logic [CNT_W-1:0] rate_out,
    output logic             rate_valid,
`ifdef LIF_MON_ISI_EN
    output logic [ISI_W-1:0] isi_out,
    output logic             isi_valid,
`endif
    output logic             busy
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e             state_q;
    logic               spike_q;
    logic [WIN_W-1:0]   win_q;
    logic [WIN_W-1:0]   timer_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               spike_event;
    logic [CNT_W-1:0]   cnt_next;
    logic               win_end;

`ifdef LIF_MON_ISI_EN
    logic [ISI_W-1:0]   isi_cnt_q;
    logic               isi_armed_q;
    logic [ISI_W-1:0]   isi_inc;
`endif

    // Edge detect and saturating next-count (includes the event of the current cycle).
    always_comb begin
        spike_event = spike_in & ~spike_q;
        cnt_next    = cnt_q;
        if (spike_event && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_next = cnt_q + CNT_W'(1);
        end
        win_end = (timer_q == win_q);
`ifdef LIF_MON_ISI_EN
        isi_inc = isi_cnt_q;
        if (isi_cnt_q != {ISI_W{1'b1}}) begin
            isi_inc = isi_cnt_q + ISI_W'(1);
        end
`endif
    end

    assign busy = (state_q == StRun);

    // FSM, window timer, spike counter and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            spike_q    <= 1'b0;
            win_q      <= '0;
            timer_q    <= '0;
            cnt_q      <= '0;
            rate_out   <= '0;
            rate_valid <= 1'b0;
`ifdef LIF_MON_ISI_EN
            isi_cnt_q   <= '0;
            isi_armed_q <= 1'b0;
            isi_out     <= '0;
            isi_valid   <= 1'b0;
`endif
        end else begin
            // spike_q follows the line in every state so edges straddling RUN entry count once.
            spike_q    <= spike_in;
            rate_valid <= 1'b0;
`ifdef LIF_MON_ISI_EN
            isi_valid  <= 1'b0;
`endif
            unique case (state_q)
                StIdle: begin
                    timer_q <= '0;
                    cnt_q   <= '0;
`ifdef LIF_MON_ISI_EN
                    isi_cnt_q   <= '0;
                    isi_armed_q <= 1'b0;
`endif
                    if (enable) begin
                        win_q   <= window_len;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    if (!enable) begin
                        // Abort: partial window dropped, rate_out keeps its last value.
                        state_q <= StIdle;
                        timer_q <= '0;
                        cnt_q   <= '0;
`ifdef LIF_MON_ISI_EN
                        isi_cnt_q   <= '0;
                        isi_armed_q <= 1'b0;
`endif
                    end else begin
                        if (win_end) begin
                            rate_out   <= cnt_next;
                            rate_valid <= 1'b1;
                            timer_q    <= '0;
                            cnt_q      <= '0;
                            win_q      <= window_len;
                        end else begin
                            timer_q <= timer_q + WIN_W'(1);
                            cnt_q   <= cnt_next;
                        end
`ifdef LIF_MON_ISI_EN
                        if (spike_event) begin
                            isi_cnt_q <= '0;
                            if (!isi_armed_q) begin
                                // First spike only opens the interval.
                                isi_armed_q <= 1'b1;
                            end else begin
                                isi_out   <= isi_inc;
                                isi_valid <= 1'b1;
                            end
                        end else begin
                            isi_cnt_q <= isi_inc;
                        end
`endif
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_lif_spike_monitor.sv
// Self-checking bench for lif_spike_monitor. A second instance with CNT_W=2 covers saturation.
module tb_lif_spike_monitor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       spike_in;
    logic       enable;
    logic [7:0] window_len;
    logic [7:0] rate_out;
    logic       rate_valid;
    logic       busy;
    logic [1:0] sat_rate;
    logic       sat_valid;
    logic       sat_busy;
`ifdef LIF_MON_ISI_EN
    logic [7:0] isi_out;
    logic       isi_valid;
    logic [7:0] sat_isi;
    logic       sat_isi_valid;
`endif

    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;
    int rate_val_q[$];
    int rate_cyc_q[$];
    int sat_val_q[$];
    int sat_cyc_q[$];
    int isi_val_q[$];
    int isi_cyc_q[$];
    bit sat_on = 1'b0;
    bit isi_on = 1'b0;
    int c0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    lif_spike_monitor u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .spike_in   (spike_in),
        .enable     (enable),
        .window_len (window_len),
        .rate_out   (rate_out),
        .rate_valid (rate_valid),
`ifdef LIF_MON_ISI_EN
        .isi_out    (isi_out),
        .isi_valid  (isi_valid),
`endif
        .busy       (busy)
    );

    lif_spike_monitor #(.CNT_W(2)) u_sat (
        .clk        (clk),
        .rst_n      (rst_n),
        .spike_in   (spike_in),
        .enable     (enable),
        .window_len (window_len),
        .rate_out   (sat_rate),
        .rate_valid (sat_valid),
`ifdef LIF_MON_ISI_EN
        .isi_out    (sat_isi),
        .isi_valid  (sat_isi_valid),
`endif
        .busy       (sat_busy)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Scoreboard monitors: each strobe pops the expected value and cycle.
    always @(negedge clk) begin
        int v;
        int c;
        if (rate_valid === 1'b1) begin
            if (rate_val_q.size() == 0) begin
                chk("rate_unexpected", 1, 0);
            end else begin
                v = rate_val_q.pop_front();
                c = rate_cyc_q.pop_front();
                chk("rate_val", int'(rate_out), v);
                chk("rate_cyc", cyc, c);
            end
        end
        if (sat_on && sat_valid === 1'b1) begin
            if (sat_val_q.size() == 0) begin
                chk("sat_unexpected", 1, 0);
            end else begin
                v = sat_val_q.pop_front();
                c = sat_cyc_q.pop_front();
                chk("sat_val", int'(sat_rate), v);
                chk("sat_cyc", cyc, c);
            end
        end
`ifdef LIF_MON_ISI_EN
        if (isi_on && isi_valid === 1'b1) begin
            if (isi_val_q.size() == 0) begin
                chk("isi_unexpected", 1, 0);
            end else begin
                v = isi_val_q.pop_front();
                c = isi_cyc_q.pop_front();
                chk("isi_val", int'(isi_out), v);
                chk("isi_cyc", cyc, c);
            end
        end
`endif
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        enable     = 1'b0;
        window_len = 8'd0;
        spike_in   = 1'b0;

        // Reset held for 3 cycles with spike_in toggling.
        for (int i = 0; i < 3; i++) begin
            spike_in = ~spike_in;
            tick(1);
        end
        chk("reset_rate_out", int'(rate_out), 0);
        chk("reset_rate_valid", int'(rate_valid), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_sat_rate", int'(sat_rate), 0);
`ifdef LIF_MON_ISI_EN
        chk("reset_isi_out", int'(isi_out), 0);
        chk("reset_isi_valid", int'(isi_valid), 0);
`endif
        spike_in = 1'b0;
        rst_n    = 1'b1;
        tick(2);

        // Rate: 10-cycle windows, spikes at run cycles 2,5,7 then an empty window.
        c0 = cyc;
        window_len = 8'd9;
        enable = 1'b1;
        rate_val_q.push_back(3); rate_cyc_q.push_back(c0 + 11);
        rate_val_q.push_back(0); rate_cyc_q.push_back(c0 + 21);
        tick(1);
        chk("busy_run", int'(busy), 1);
        for (int k = 0; k <= 20; k++) begin
            spike_in = (k == 2 || k == 5 || k == 7);
            if (k == 20) enable = 1'b0;
            tick(1);
        end
        tick(3);
        chk("busy_idle", int'(busy), 0);

        // Boundary: spike in window-end cycle held into next window, then enable abort.
        c0 = cyc;
        window_len = 8'd4;
        enable = 1'b1;
        rate_val_q.push_back(1); rate_cyc_q.push_back(c0 + 6);
        rate_val_q.push_back(0); rate_cyc_q.push_back(c0 + 11);
        rate_val_q.push_back(2); rate_cyc_q.push_back(c0 + 16);
        tick(1);
        for (int k = 0; k <= 18; k++) begin
            spike_in = (k >= 4 && k <= 6) || k == 11 || k == 13 || k == 15 || k == 17;
            enable = (k != 18);
            tick(1);
        end
        spike_in = 1'b0;
        tick(3);
        chk("abort_hold_rate", int'(rate_out), 2);
        chk("abort_busy", int'(busy), 0);

        // Reset mid-window after 2 spikes.
        window_len = 8'd9;
        enable = 1'b1;
        tick(1);
        for (int k = 0; k <= 5; k++) begin
            spike_in = (k == 1 || k == 3);
            if (k == 5) begin
                rst_n  = 1'b0;
                enable = 1'b0;
            end
            tick(1);
        end
        rst_n = 1'b1;
        tick(3);
        chk("reset_abort_rate", int'(rate_out), 0);
        chk("reset_abort_busy", int'(busy), 0);

        // Saturation (CNT_W=2) with 5 pulses, then a 6-cycle held level.
        sat_on = 1'b1;
        c0 = cyc;
        window_len = 8'd20;
        enable = 1'b1;
        rate_val_q.push_back(5); rate_cyc_q.push_back(c0 + 22);
        rate_val_q.push_back(1); rate_cyc_q.push_back(c0 + 43);
        sat_val_q.push_back(3);  sat_cyc_q.push_back(c0 + 22);
        sat_val_q.push_back(1);  sat_cyc_q.push_back(c0 + 43);
        tick(1);
        for (int k = 0; k <= 42; k++) begin
            spike_in = (k < 10 && (k % 2) == 1) || (k >= 22 && k <= 27);
            enable = (k != 42);
            tick(1);
        end
        spike_in = 1'b0;
        tick(3);
        sat_on = 1'b0;

`ifdef LIF_MON_ISI_EN
        // ISI: events at run cycles 4, 10, 13.
        isi_on = 1'b1;
        c0 = cyc;
        window_len = 8'd255;
        enable = 1'b1;
        isi_val_q.push_back(6); isi_cyc_q.push_back(c0 + 12);
        isi_val_q.push_back(3); isi_cyc_q.push_back(c0 + 15);
        tick(1);
        for (int k = 0; k <= 16; k++) begin
            spike_in = (k == 4 || k == 10 || k == 13);
            enable = (k != 16);
            tick(1);
        end
        spike_in = 1'b0;
        tick(3);
        isi_on = 1'b0;
        chk("isi_left", isi_val_q.size(), 0);
`endif

        chk("rate_left", rate_val_q.size(), 0);
        chk("sat_left", sat_val_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
